// File: rtl/mac_pkg.sv
// Shared types and default dimensions for the MAC array datapath.
package mac_pkg;

  localparam int PSUM_BW = 16;
  localparam int COL     = 8;
  localparam int DEPTH   = 64;

  typedef logic [PSUM_BW-1:0] psum_t;
  typedef psum_t [COL-1:0]    psum_row_t;

endpackage

// File: rtl/ofifo_col.sv
// Single-column psum FIFO: storage, write pointer and occupancy count.
// The read pointer lives in the top so all columns pop the same slot.
module ofifo_col
  import mac_pkg::*;
#(
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = DEPTH,
  localparam int AW     = $clog2(depth)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic [psum_bw-1:0] din,
  input  logic               pop,
  input  logic [AW-1:0]      raddr,
  output logic [psum_bw-1:0] dout,
  output logic               empty,
  output logic               full,
  output logic               drop
);

  logic [psum_bw-1:0] mem_q [depth];
  logic [AW-1:0]      wptr_q, wptr_d;
  logic [AW:0]        cnt_q, cnt_d;
  logic               push;

  assign full  = (cnt_q == (AW+1)'(depth));
  assign empty = (cnt_q == '0);
  assign dout  = mem_q[raddr];

  // A pop on the same edge frees the slot, so a write to a full column still lands.
  always_comb begin
    push   = wr && (!full || pop);
    drop   = wr && full && !pop;
    wptr_d = push ? wptr_q + 1'b1 : wptr_q;
    cnt_d  = cnt_q;
    if (push && !pop)
      cnt_d = cnt_q + 1'b1;
    else if (!push && pop)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/psum_ofifo.sv
// Output FIFO for the systolic array south edge: collects skewed column psums
// and releases one aligned row per read once every column holds data.
module psum_ofifo
  import mac_pkg::*;
#(
  parameter int col     = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [col-1:0][psum_bw-1:0] in,
  input  logic [col-1:0]              wr,
  input  logic                        rd,
  output logic                        o_ready,
  output logic                        o_full,
  output logic                        o_valid,
  output logic [col-1:0][psum_bw-1:0] out,
  output logic                        o_ovf
);

  localparam int AW = $clog2(depth);

  logic [col-1:0]              empty_v, full_v, drop_v;
  logic [col-1:0][psum_bw-1:0] row;
  logic [AW-1:0]               rptr_q, rptr_d;
  logic [col-1:0][psum_bw-1:0] out_q, out_d;
  logic                        valid_q, valid_d;
  logic                        ovf_q, ovf_d;
  logic                        accept;

  for (genvar c = 0; c < col; c++) begin : g_col
    ofifo_col #(
      .psum_bw(psum_bw),
      .depth  (depth)
    ) u_col (
      .clk  (clk),
      .reset(reset),
      .wr   (wr[c]),
      .din  (in[c]),
      .pop  (accept),
      .raddr(rptr_q),
      .dout (row[c]),
      .empty(empty_v[c]),
      .full (full_v[c]),
      .drop (drop_v[c])
    );
  end

  // Flags come only from registered counts, keeping rd/wr off the output paths.
  assign o_ready = &(~empty_v);
  assign o_full  = |full_v;
  assign accept  = rd && o_ready;

  always_comb begin
    rptr_d  = accept ? rptr_q + 1'b1 : rptr_q;
    out_d   = accept ? row : out_q;
    valid_d = accept;
    ovf_d   = ovf_q | (|drop_v);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rptr_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      rptr_q  <= rptr_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out     = out_q;
  assign o_valid = valid_q;
  assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_psum_ofifo.sv
// Scoreboard bench for psum_ofifo: driver queues expected rows, negedge monitor checks pops.
module tb_psum_ofifo;

  typedef logic [7:0][15:0] row_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  row_t        din = '0;
  logic [7:0]  wr = '0;
  logic        rd = 1'b0;
  logic        o_ready, o_full, o_valid, o_ovf;
  row_t        dout;

  int n_chk = 0;
  int n_fail = 0;
  row_t sb[$];

  psum_ofifo #(.col(8), .psum_bw(16), .depth(64)) dut (
    .clk    (clk),
    .reset  (reset),
    .in     (din),
    .wr     (wr),
    .rd     (rd),
    .o_ready(o_ready),
    .o_full (o_full),
    .o_valid(o_valid),
    .out    (dout),
    .o_ovf  (o_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every o_valid pulse must match the oldest queued row.
  always @(negedge clk) begin
    if (reset && o_valid) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got %h expected no o_valid", dout);
      end else begin
        row_t e;
        e = sb.pop_front();
        if (dout !== e) begin
          n_fail++;
          $display("FAIL pop_data: got %h expected %h", dout, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    sb.delete();
    wr = '0;
    rd = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  function automatic row_t mkrow(input logic [15:0] base, input int r);
    row_t v;
    for (int c = 0; c < 8; c++) v[c] = base + 16'(r * 16 + c);
    return v;
  endfunction

  initial begin
    row_t x, fresh;

    // 1: reset and idle
    tick();
    chk("rst_ready", o_ready, 0);
    chk("rst_full", o_full, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_ovf", o_ovf, 0);
    chk("rst_out", dout, 0);
    reset = 1'b1;
    tick();
    rd = 1'b1;
    tick(); tick(); tick();
    rd = 1'b0;
    chk("idle_rd_valid", o_valid, 0);
    chk("idle_rd_ready", o_ready, 0);

    // 2: skewed single row
    for (int c = 0; c < 8; c++) begin
      din[c] = 16'h0100 + 16'(c);
      wr = 8'(1 << c);
      tick();
      wr = '0;
      chk($sformatf("skew_ready_c%0d", c), o_ready, (c == 7));
    end
    for (int c = 0; c < 8; c++) x[c] = 16'h0100 + 16'(c);
    sb.push_back(x);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    tick(); tick();
    chk("skew_drained", o_ready, 0);

    // 3: diagonal burst of 64 rows fills every column
    for (int r = 0; r < 64; r++) sb.push_back(mkrow(16'hA000, r));
    for (int t = 0; t < 71; t++) begin
      wr = '0;
      for (int c = 0; c < 8; c++) begin
        if (t - c >= 0 && t - c < 64) begin
          wr[c] = 1'b1;
          din[c] = 16'hA000 + 16'((t - c) * 16 + c);
        end
      end
      tick();
    end
    wr = '0;
    chk("burst_full", o_full, 1);
    chk("burst_ready", o_ready, 1);
    chk("burst_ovf0", o_ovf, 0);
    din[3] = 16'hDEAD;
    wr = 8'h08;
    tick();
    wr = '0;
    chk("drop_ovf", o_ovf, 1);
    chk("drop_full", o_full, 1);
    rd = 1'b1;
    for (int i = 0; i < 66; i++) tick();
    rd = 1'b0;
    tick();
    chk("burst_empty_ready", o_ready, 0);
    chk("burst_empty_full", o_full, 0);
    chk("ovf_sticky", o_ovf, 1);
    chk("burst_sb_empty", sb.size(), 0);

    // 4: full with simultaneous read and write
    do_reset();
    chk("rst2_ovf", o_ovf, 0);
    for (int r = 0; r < 64; r++) begin
      din = mkrow(16'h4000, r);
      sb.push_back(din);
      wr = 8'hFF;
      tick();
    end
    wr = '0;
    chk("sim_full_pre", o_full, 1);
    x = mkrow(16'h7000, 5);
    din = x;
    sb.push_back(x);
    wr = 8'hFF;
    rd = 1'b1;
    tick();
    wr = '0;
    chk("sim_full_post", o_full, 1);
    chk("sim_ovf", o_ovf, 0);
    for (int i = 0; i < 64; i++) tick();
    rd = 1'b0;
    tick();
    chk("sim_drained", o_ready, 0);
    chk("sim_sb_empty", sb.size(), 0);

    // 5: streaming 200 rows across pointer wrap
    rd = 1'b1;
    for (int i = 0; i < 200; i++) begin
      for (int c = 0; c < 8; c++) din[c] = 16'(c << 12) | 16'(i);
      sb.push_back(din);
      wr = 8'hFF;
      tick();
    end
    wr = '0;
    tick(); tick(); tick();
    rd = 1'b0;
    tick();
    chk("wrap_sb_empty", sb.size(), 0);
    chk("wrap_ready", o_ready, 0);
    chk("wrap_ovf", o_ovf, 0);

    // 6: async reset between edges mid-burst
    for (int r = 0; r < 5; r++) begin
      din = mkrow(16'h2000, r);
      wr = 8'hFF;
      tick();
    end
    chk("pre_rst_ready", o_ready, 1);
    #2;
    reset = 1'b0;
    sb.delete();
    #1;
    chk("async_ready", o_ready, 0);
    chk("async_full", o_full, 0);
    chk("async_valid", o_valid, 0);
    chk("async_out", dout, 0);
    wr = '0;
    tick();
    #2;
    reset = 1'b1;
    tick();
    chk("post_rst_ready", o_ready, 0);
    fresh = mkrow(16'h5500, 3);
    din = fresh;
    sb.push_back(fresh);
    wr = 8'hFF;
    tick();
    wr = '0;
    rd = 1'b1;
    tick();
    rd = 1'b0;
    tick(); tick();
    chk("fresh_out", dout, fresh);
    chk("final_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
